// File: rtl/sw_out_arb_pkg.sv
// Shared switch definitions: packet width, destination field placement and
// round-robin pointer width, used by the output arbiter and its picker.
// This file carries the sw.vh packet-width macro so every file compiled after
// it sees the same `PKTW.
`ifndef PKTW
`define PKTW 16
`endif

package sw_out_arb_pkg;
  // Destination code location inside a packet word
  localparam int DEST_LSB = 0;
  localparam int DESTW    = 4;
  // Width of the stored last-grant index (supports up to 16 inputs)
  localparam int RR_PTRW  = 4;
  // Width of each per-input grant counter when statistics are built in
  localparam int STATW    = 16;
endpackage

// File: rtl/sw_rr_pick.sv
// Round-robin picker: returns a one-hot grant for the first requesting index
// strictly after the last grant, wrapping to 0. Purely combinational.
module sw_rr_pick
  import sw_out_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       i_req,
  input  logic [RR_PTRW-1:0] i_last,
  output logic [N-1:0]       o_grant,
  output logic               o_any
);

  // Scan N positions starting just after the last grant and take the first hit
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!o_any && i_req[(int'(i_last) + k) % N]) begin
        o_grant[(int'(i_last) + k) % N] = 1'b1;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_out_arb.sv
// Switch output-port arbiter: pops one eligible input FIFO head per free
// output slot in round-robin order and holds it in a registered output stage.
// Optional build macro SW_ARB_STATS_EN adds per-input grant counters (pkt_cnt).
module sw_out_arb
  import sw_out_arb_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int PORT_ID = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN-1:0][`PKTW:0]  in_data,
  input  logic [N_IN-1:0]           in_empty,
  output logic [N_IN-1:0]           in_re,
  output logic [`PKTW:0]            out_data,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef SW_ARB_STATS_EN
  ,
  output logic [N_IN-1:0][STATW-1:0] pkt_cnt
`endif
);

  localparam logic [DESTW-1:0]   PORT_CODE = DESTW'(PORT_ID);
  localparam logic [RR_PTRW-1:0] LAST_RST  = RR_PTRW'(N_IN - 1);

  logic [N_IN-1:0]    w_elig;
  logic [N_IN-1:0]    w_gnt;
  logic               w_any;
  logic               w_free;
  logic [RR_PTRW-1:0] w_gidx;
  logic [`PKTW:0]     w_gdata;

  logic [RR_PTRW-1:0] r_last;
  logic [`PKTW:0]     r_data;
  logic               r_valid;

  // An input competes only if its FIFO has a head addressed to this port
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_elig[i] = !in_empty[i] && (in_data[i][DEST_LSB +: DESTW] == PORT_CODE);
    end
  end

  // The output slot can take a new word when empty or being drained this cycle
  assign w_free = !r_valid || out_ready;

  sw_rr_pick #(
    .N (N_IN)
  ) u_pick (
    .i_req   (w_elig),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_any   (w_any)
  );

  // Pop strobe is held off during reset so nothing is lost while the port is down
  assign in_re = (rst && w_free) ? w_gnt : '0;

  // Turn the one-hot grant into an index and the matching head word
  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_gnt[i]) begin
        w_gidx  = RR_PTRW'(i);
        w_gdata = in_data[i];
      end
    end
  end

  // Output stage: load on grant, drop valid when drained with nothing to replace it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= LAST_RST;
    end else if (w_free) begin
      if (w_any) begin
        r_data  <= w_gdata;
        r_valid <= 1'b1;
        r_last  <= w_gidx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;

`ifdef SW_ARB_STATS_EN
  logic [N_IN-1:0][STATW-1:0] r_cnt;

  // Count grants per input; counters wrap naturally at their width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_re[i]) begin
          r_cnt[i] <= r_cnt[i] + STATW'(1);
        end
      end
    end
  end

  assign pkt_cnt = r_cnt;
`endif

endmodule

// File: doc/sw_out_arb.md
SW_OUT_ARB -- requirements
Module: sw_out_arb

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of input FIFOs feeding this output port.
REQ-002 SHALL have parameter PORT_ID, default 0: destination code served by this port.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-low, no synchronous reset path.
REQ-005 SHALL have port in_data, input, N_IN x (`PKTW+1): head word of each input FIFO.
REQ-006 SHALL have port in_empty, input, N_IN: empty flag of each input FIFO.
REQ-007 SHALL have port in_re, output, N_IN: pop strobe to each input FIFO.
REQ-008 SHALL have port out_data, output, `PKTW+1: registered forwarded packet.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a packet.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.

Function
REQ-011 SHALL treat input i as eligible when in_empty[i]==0 and in_data[i] dest field == PORT_ID.
REQ-012 SHALL define "slot free" as out_valid==0, or out_valid==1 and out_ready==1.
REQ-013 SHALL, when the slot is free and at least one input is eligible, grant exactly one input in the same cycle, with in_re for that input combinational and high for one cycle only.
REQ-014 SHALL choose the grant round-robin: the first eligible index strictly after last_grant, wrapping from N_IN-1 to 0.
REQ-015 SHALL, on a grant, load in_data[g] into out_data at the next edge, set out_valid=1, and set last_grant=g; latency is one cycle from pop to out_valid.
REQ-016 SHALL, when the slot is free and no input is eligible, clear out_valid at the next edge and leave out_data and last_grant unchanged.
REQ-017 SHALL hold out_data and out_valid stable while out_valid==1 and out_ready==0, with all in_re low.
REQ-018 SHALL never assert in_re[i] while in_empty[i]==1, and never assert more than one in_re bit.
REQ-019 SHALL sustain one packet per cycle when out_ready is held high and eligible inputs exist (back-to-back pop on simultaneous drain and refill).
REQ-020 SHALL ignore ineligible heads; they stay in their FIFO without blocking other inputs.

Reset
REQ-021 SHALL, while rst==0, force out_valid=0, out_data=0, last_grant=N_IN-1 (so input 0 wins first), and in_re=0.
REQ-022 SHALL, on reset mid-transfer, discard the held packet; popped words are not replayed.

Configuration
REQ-023 SHALL, with macro SW_ARB_STATS_EN defined, add output pkt_cnt (N_IN x 16) that counts grants per input, wraps modulo 2^16, and is cleared by reset.
REQ-024 SHALL, without SW_ARB_STATS_EN, omit pkt_cnt and its counters entirely, with function otherwise identical.

Structure
REQ-025 SHALL take `PKTW from sw.vh and place DEST_LSB, DESTW and the round-robin pointer width in the shared sw package/header; no local redefinition.
REQ-026 SHALL implement the round-robin pick as one sub-module, sw_rr_pick (request vector, last_grant -> one-hot grant, any), with combinational output only.

Verification
REQ-027 Reset: rst=0 with all FIFOs non-empty -> in_re=0, out_valid=0, out_data=0; after rst=1, first grant goes to input 0.
REQ-028 Round-robin: inputs 0-3 each hold 3 packets for PORT_ID, out_ready=1 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3 and 12 consecutive valid cycles.
REQ-029 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data unchanged, in_re=0 all 5 cycles; release -> next pop in the same cycle.
REQ-030 Filtering: input 1 head dest=PORT_ID+1, input 2 head dest=PORT_ID -> only in_re[2] fires; input 1 head never popped.
REQ-031 Empty boundary: single packet in input 3, all others empty -> one pop, then out_valid drops the cycle after acceptance; in_re never high while empty.
REQ-032 Stats (SW_ARB_STATS_EN): 70000 grants to input 0 -> pkt_cnt[0]==4464 (wrapped), and a mid-run reset clears all counters to 0.
